adc_chan_packer: RTL and testbench
==================================

# adc_chan_packer

Parametrised receive-path packer behind the AD9361 LVDS interface. It takes the per-sample `adc_valid`/`adc_data` lane bundle (NUM_CH complex channels, I/Q per channel) and applies `adc_r1_mode` and a per-channel enable mask. Each captured sample set is buffered in a first-word-fall-through FIFO, then serialised as one complex sample per beat onto a valid/ready stream tagged with channel index and start-of-set. It generalises the fixed 2R2T ADC hand-off to any channel count and adds backpressure, overflow detection and drop counting.

## Interface
- NUM_CH, 2: complex channels carried on `adc_data`; must be ≥1.
- SAMPLE_W, 12: bits per I or Q lane, two's complement.
- OUT_W, 16: output bits per I or Q, sign-extended; must be ≥ SAMPLE_W.
- FIFO_DEPTH, 16: sample sets buffered; power of two, ≥2.
- CH_W, derived: max(1, $clog2(NUM_CH)).
- clk  in  1  interface clock (adc clock domain).
- rst_n  in  1  asynchronous, active-low reset.
- adc_valid  in  1  sample-set strobe from LVDS interface.
- adc_data  in  2*NUM_CH*SAMPLE_W  lanes LSB-first: I0, Q0, I1, Q1, …
- adc_r1_mode  in  1  1 = single-channel mode; only channel 0 is eligible.
- ch_enable  in  NUM_CH  per-channel capture mask.
- enable  in  1  capture enable; 0 blocks FIFO writes.
- out_ready  in  1  downstream ready.
- out_valid  out  1  beat valid.
- out_data  out  2*OUT_W  {Q, I}, I in low OUT_W bits.
- out_chan  out  CH_W  channel index of beat.
- out_sof  out  1  first beat of a sample set.
- overflow  out  1  sticky: a set was dropped.
- overflow_clr  in  1  clears `overflow` and `drop_count`.
- drop_count  out  16  dropped sets, saturates at 0xFFFF.
- fifo_level  out  $clog2(FIFO_DEPTH+1)  sets held.

## Operation
- Effective mask: `ch_enable & (adc_r1_mode ? 1 : all-ones)`. It is sampled with the data at capture and stored in the entry. Later mask or mode changes affect only later sets.
- Capture: `adc_valid & enable & (mask != 0)` writes {adc_data, mask} to the FIFO. A set with an empty mask or captured while `enable` = 0 is ignored silently and does not count as overflow.
- Accept rule: write succeeds if `fifo_level < FIFO_DEPTH` or the head is popped in the same cycle.
- Full: otherwise the whole set is dropped, `overflow` is set, and `drop_count` increments (saturating).
- Overflow clear: `overflow_clr` clears both `overflow` and `drop_count`. If a drop occurs in the same cycle, the set wins: `overflow` = 1 and `drop_count` = 1.
- Serialiser: a channel pointer scans the head entry's mask in ascending channel order.
  - IDLE: FIFO empty, `out_valid` = 0.
  - EMIT: `out_valid` = 1, pointer at the lowest set mask bit on entry.
  - Each handshake advances the pointer to the next set bit.
  - The handshake on the highest set bit pops the head. The pointer goes back to the first set bit of the new head, or to IDLE if the FIFO is empty.
- `out_sof` = 1 only on the first enabled channel of each set.
- Sign extension: each lane is replicated from bit SAMPLE_W-1 up to OUT_W.
- `enable` falling mid-stream: entries already in the FIFO drain normally.

## Timing
- Reset values: `out_valid`, `out_data`, `out_chan`, `out_sof`, `overflow`, `drop_count`, `fifo_level` are all 0. FIFO is empty and the pointer is at 0.
- Reset mid-operation discards all contents immediately; `out_valid` drops asynchronously.
- Latency: a set captured at edge k gives `out_valid` = 1 in the cycle after edge k when the FIFO was empty.
- Stream rules:
  - Once `out_valid` = 1, `out_data`/`out_chan`/`out_sof` stay stable until `out_ready`.
  - `out_valid` does not drop without a handshake except on reset.
- Throughput: one beat per cycle; back-to-back sets emit with no bubble.
- Sustained input rate must satisfy popcount(mask) beats per `adc_valid` period, or overflow results.
- `fifo_level` is registered and reflects writes/pops of the previous edge; a simultaneous write and pop leaves it unchanged.

## Structure
- Package `adc_pack_pkg`: lane-slice function (channel, I/Q → bit offset), sign-extend function, first-set-bit / next-set-bit functions over the NUM_CH mask, and the `drop_count` width constant.
- Sub-module `adc_pack_fifo`: synchronous FWFT FIFO with width 2*NUM_CH*SAMPLE_W + NUM_CH, depth FIFO_DEPTH, async active-low reset, and a level output.
- Top `adc_chan_packer`: capture/accept logic, overflow counters, serialiser pointer.

## Test plan
- Reset: assert `rst_n` = 0 mid-stream → all outputs 0 within the same cycle; `fifo_level` = 0 after release.
- NUM_CH=2, mask 2'b11, r1 = 0, lanes I0=0x7FF, Q0=0x800, I1=0x001, Q1=0xFFF, ready = 1 → two beats:
  - beat 1: 32'hF800_07FF, chan 0, sof 1
  - beat 2: 32'hFFFF_0001, chan 1, sof 0
  - first beat appears one cycle after capture.
- Same stimulus with `adc_r1_mode` = 1 → a single beat 32'hF800_07FF, chan 0, sof 1. Mask 2'b10 with r1 = 0 → a single beat chan 1, sof 1.
- Overflow, ready = 0: push 17 sets → `fifo_level` = 16, `overflow` = 1, `drop_count` = 1. Release ready → 16 sets emerge in order. Pulse `overflow_clr` → both cleared.
- Backpressure: toggle `out_ready` at random → data stable while valid & !ready, no beat lost or duplicated across 1000 sets.
- Boundaries:
  - mask 0 with `adc_valid` → no write, no overflow.
  - `enable` dropped after 3 sets → those 3 drain, later `adc_valid` ignored.
  - full FIFO with a same-cycle last-beat pop → write accepted, no drop.

Source files
------------

// File: rtl/adc_pack_pkg.sv
// Shared helpers for the ADC channel packer.
//   lane_offset : bit offset of a channel's I or Q lane inside the packed lane bundle
//   sign_extend : widens a SAMPLE_W two's complement value held in the low bits of a word
//   first_set   : index of the lowest set bit of a channel mask (MAX_CH when empty)
//   next_set    : index of the lowest set bit above a given channel (MAX_CH when none)
//   DROP_W      : width of the dropped-set counter
package adc_pack_pkg;

   localparam int MAX_CH = 32;
   localparam int MAX_W  = 64;
   localparam int DROP_W = 16;

   typedef enum logic {
      SER_IDLE,
      SER_EMIT
   } ser_state_e;

   function automatic int lane_offset(int ch, logic is_q, int sample_w);
      return (2 * ch + (is_q ? 1 : 0)) * sample_w;
   endfunction

   // Shift-based so the sign position can be a run-time width without bit-select indexing.
   function automatic logic [MAX_W-1:0] sign_extend(logic [MAX_W-1:0] v, int sample_w);
      logic [MAX_W-1:0] keep;
      logic             sign;
      keep = (MAX_W'(1) << sample_w) - MAX_W'(1);
      sign = |(v & (MAX_W'(1) << (sample_w - 1)));
      return sign ? (v | ~keep) : (v & keep);
   endfunction

   function automatic int next_set(logic [MAX_CH-1:0] mask, int cur);
      logic [MAX_CH-1:0] tmp;
      int                r;
      r = MAX_CH;
      for (int i = MAX_CH - 1; i >= 0; i--) begin
         tmp = mask >> i;
         if (tmp[0] && (i > cur)) r = i;
      end
      return r;
   endfunction

   function automatic int first_set(logic [MAX_CH-1:0] mask);
      return next_set(mask, -1);
   endfunction

endpackage

// File: rtl/adc_pack_fifo.sv
// First-word-fall-through FIFO holding captured sample sets.
//   clk, rst_n : clock, async active-low reset (pointers and level only)
//   wr_en      : push wr_data (caller guarantees room, or a same-cycle pop when full)
//   rd_en      : pop head (caller guarantees non-empty)
//   rd_data    : current head entry, valid whenever level != 0
//   nxt_tag    : top TAG_W bits of the entry behind the head, valid when level >= 2
//   level      : number of entries held
module adc_pack_fifo #(
   parameter  int WIDTH = 8,
   parameter  int TAG_W = 1,
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH),
   localparam int LVL_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic [TAG_W-1:0] nxt_tag,
   output logic [LVL_W-1:0] level
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [WIDTH-1:0] nxt_ent;

   // When full, the write slot is the head slot; a same-cycle pop has already
   // consumed the old head combinationally, so overwriting it at the edge is safe.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (rd_en) rd_ptr <= rd_ptr + AW'(1);
         case ({wr_en, rd_en})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
      end
   end

   assign rd_data = mem[rd_ptr];
   assign nxt_ent = mem[rd_ptr + AW'(1)];
   assign nxt_tag = nxt_ent[WIDTH-1 -: TAG_W];

endmodule

// File: rtl/adc_chan_packer.sv
// Receive-path packer: captures masked ADC sample sets into a FIFO and
// serialises them one complex sample per beat on a valid/ready stream.
//   clk, rst_n          : interface clock, async active-low reset
//   adc_valid, adc_data : sample-set strobe and lanes I0,Q0,I1,Q1,... LSB-first
//   adc_r1_mode         : single-channel mode, only channel 0 eligible
//   ch_enable, enable   : per-channel capture mask, global capture enable
//   out_valid/ready     : stream handshake
//   out_data            : {Q, I}, each sign-extended to OUT_W
//   out_chan, out_sof   : channel of the beat, first beat of a set
//   overflow, drop_count: sticky drop flag and saturating dropped-set count
//   overflow_clr        : clears overflow and drop_count
//   fifo_level          : sets held in the FIFO
//
// Serialiser states:
//   state    | meaning
//   SER_IDLE | FIFO empty, no beat offered
//   SER_EMIT | beat offered for head entry, ptr = current channel
module adc_chan_packer
   import adc_pack_pkg::*;
#(
   parameter  int NUM_CH     = 2,
   parameter  int SAMPLE_W   = 12,
   parameter  int OUT_W      = 16,
   parameter  int FIFO_DEPTH = 16,
   localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         adc_valid,
   input  logic [2*NUM_CH*SAMPLE_W-1:0] adc_data,
   input  logic                         adc_r1_mode,
   input  logic [NUM_CH-1:0]            ch_enable,
   input  logic                         enable,
   input  logic                         out_ready,
   output logic                         out_valid,
   output logic [2*OUT_W-1:0]           out_data,
   output logic [CH_W-1:0]              out_chan,
   output logic                         out_sof,
   output logic                         overflow,
   input  logic                         overflow_clr,
   output logic [DROP_W-1:0]            drop_count,
   output logic [LVL_W-1:0]             fifo_level
);

   localparam int DATA_W = 2 * NUM_CH * SAMPLE_W;
   localparam int ENT_W  = DATA_W + NUM_CH;

   logic [NUM_CH-1:0]   mask_eff;
   logic                wr_req;
   logic                accept;
   logic                wr_en;
   logic                drop;
   logic                hs;
   logic                last_beat;
   logic                pop;
   logic [ENT_W-1:0]    head_ent;
   logic [DATA_W-1:0]   head_data;
   logic [NUM_CH-1:0]   head_mask;
   logic [NUM_CH-1:0]   next_mask;
   logic [LVL_W-1:0]    level;
   ser_state_e          state;
   ser_state_e          state_nxt;
   logic [CH_W-1:0]     ptr;
   logic [CH_W-1:0]     ptr_nxt;
   logic [SAMPLE_W-1:0] lane_i;
   logic [SAMPLE_W-1:0] lane_q;
   logic [OUT_W-1:0]    ext_i;
   logic [OUT_W-1:0]    ext_q;

   assign mask_eff = ch_enable & (adc_r1_mode ? NUM_CH'(1) : {NUM_CH{1'b1}});
   assign wr_req   = adc_valid & enable & (|mask_eff);

   assign out_valid = (state == SER_EMIT);
   assign hs        = out_valid & out_ready;
   assign last_beat = (next_set(MAX_CH'(head_mask), int'(ptr)) >= NUM_CH);
   assign pop       = hs & last_beat;

   assign accept = (level < LVL_W'(FIFO_DEPTH)) | pop;
   assign wr_en  = wr_req & accept;
   assign drop   = wr_req & ~accept;

   adc_pack_fifo #(
      .WIDTH (ENT_W),
      .TAG_W (NUM_CH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en),
      .wr_data ({mask_eff, adc_data}),
      .rd_en   (pop),
      .rd_data (head_ent),
      .nxt_tag (next_mask),
      .level   (level)
   );

   assign {head_mask, head_data} = head_ent;
   assign fifo_level = level;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= SER_IDLE;
         ptr   <= '0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
      end
   end

   // On the last beat the next head is either the entry behind the current
   // head or, when the FIFO holds only this one, the set written this cycle.
   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      case (state)
         SER_IDLE: begin
            if (wr_en) begin
               state_nxt = SER_EMIT;
               ptr_nxt   = CH_W'(first_set(MAX_CH'(mask_eff)));
            end
         end
         SER_EMIT: begin
            if (hs) begin
               if (!last_beat) begin
                  ptr_nxt = CH_W'(next_set(MAX_CH'(head_mask), int'(ptr)));
               end else if (level > LVL_W'(1)) begin
                  ptr_nxt = CH_W'(first_set(MAX_CH'(next_mask)));
               end else if (wr_en) begin
                  ptr_nxt = CH_W'(first_set(MAX_CH'(mask_eff)));
               end else begin
                  state_nxt = SER_IDLE;
                  ptr_nxt   = '0;
               end
            end
         end
         default: begin
            state_nxt = SER_IDLE;
            ptr_nxt   = '0;
         end
      endcase
   end

   // Head data is unreset memory, so outputs are gated to read zero when idle.
   always_comb begin
      lane_i   = SAMPLE_W'(head_data >> lane_offset(int'(ptr), 1'b0, SAMPLE_W));
      lane_q   = SAMPLE_W'(head_data >> lane_offset(int'(ptr), 1'b1, SAMPLE_W));
      ext_i    = OUT_W'(sign_extend(MAX_W'(lane_i), SAMPLE_W));
      ext_q    = OUT_W'(sign_extend(MAX_W'(lane_q), SAMPLE_W));
      out_data = out_valid ? {ext_q, ext_i} : '0;
      out_chan = out_valid ? ptr : '0;
      out_sof  = out_valid & (int'(ptr) == first_set(MAX_CH'(head_mask)));
   end

   // A drop in the same cycle as a clear restarts the count at one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow   <= 1'b0;
         drop_count <= '0;
      end else if (drop) begin
         overflow <= 1'b1;
         if (overflow_clr)     drop_count <= DROP_W'(1);
         else if (~&drop_count) drop_count <= drop_count + DROP_W'(1);
      end else if (overflow_clr) begin
         overflow   <= 1'b0;
         drop_count <= '0;
      end
   end

endmodule

// File: tb/tb_adc_chan_packer.sv
module tb_adc_chan_packer;

   localparam int NUM_CH = 2;
   localparam int SW     = 12;
   localparam int DEPTH  = 16;

   logic        clk;
   logic        rst_n;
   logic        adc_valid;
   logic [47:0] adc_data;
   logic        adc_r1_mode;
   logic [1:0]  ch_enable;
   logic        enable;
   logic        out_ready;
   logic        out_valid;
   logic [31:0] out_data;
   logic [0:0]  out_chan;
   logic        out_sof;
   logic        overflow;
   logic        overflow_clr;
   logic [15:0] drop_count;
   logic [4:0]  fifo_level;

   adc_chan_packer #(
      .NUM_CH     (NUM_CH),
      .SAMPLE_W   (SW),
      .OUT_W      (16),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .adc_valid    (adc_valid),
      .adc_data     (adc_data),
      .adc_r1_mode  (adc_r1_mode),
      .ch_enable    (ch_enable),
      .enable       (enable),
      .out_ready    (out_ready),
      .out_valid    (out_valid),
      .out_data     (out_data),
      .out_chan     (out_chan),
      .out_sof      (out_sof),
      .overflow     (overflow),
      .overflow_clr (overflow_clr),
      .drop_count   (drop_count),
      .fifo_level   (fifo_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: a queue of expected beats plus set count and overflow state.
   typedef struct {
      logic [31:0] data;
      int          chan;
      bit          sof;
      bit          last;
   } beat_t;

   beat_t beats[$];
   int    sets_q  = 0;
   bit    m_ovf   = 0;
   int    m_drops = 0;
   int    tests   = 0;
   int    fails   = 0;
   int    issued  = 0;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] sx(logic [11:0] v);
      int t;
      t = $signed(v);
      return t[15:0];
   endfunction

   task automatic push_set(logic [47:0] d, logic [1:0] m);
      int    hi;
      bit    first;
      beat_t b;
      hi    = 0;
      first = 1;
      for (int ch = 0; ch < NUM_CH; ch++) if (m[ch]) hi = ch;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         if (m[ch]) begin
            b.data = {sx(d[24*ch+12 +: 12]), sx(d[24*ch +: 12])};
            b.chan = ch;
            b.sof  = first;
            b.last = (ch == hi);
            first  = 0;
            beats.push_back(b);
         end
      end
      sets_q++;
   endtask

   task automatic check_outputs(string tag);
      chk({tag, ".valid"}, out_valid, beats.size() != 0);
      if (beats.size() != 0) begin
         chk({tag, ".data"}, out_data, beats[0].data);
         chk({tag, ".chan"}, out_chan, beats[0].chan);
         chk({tag, ".sof"},  out_sof,  beats[0].sof);
      end
      chk({tag, ".level"},    fifo_level, sets_q);
      chk({tag, ".overflow"}, overflow,   m_ovf);
      chk({tag, ".drops"},    drop_count, m_drops);
   endtask

   // Inputs are set by the caller before this; one clock edge is modelled.
   task automatic cycle(string tag);
      logic [1:0] m;
      bit wr_req, hs, pop_now, acc, drop;
      m       = ch_enable & (adc_r1_mode ? 2'b01 : 2'b11);
      wr_req  = adc_valid && enable && (m != 2'b00);
      hs      = (beats.size() != 0) && out_ready;
      pop_now = hs && beats[0].last;
      acc     = (sets_q < DEPTH) || pop_now;
      drop    = wr_req && !acc;
      if (wr_req) issued++;
      @(posedge clk);
      if (hs) begin
         if (beats[0].last) sets_q--;
         void'(beats.pop_front());
      end
      if (wr_req && acc) push_set(adc_data, m);
      if (drop) begin
         m_ovf   = 1;
         m_drops = overflow_clr ? 1 : ((m_drops == 65535) ? 65535 : m_drops + 1);
      end else if (overflow_clr) begin
         m_ovf   = 0;
         m_drops = 0;
      end
      @(negedge clk);
      check_outputs(tag);
   endtask

   task automatic drain(string tag);
      adc_valid = 0;
      out_ready = 1;
      for (int i = 0; i < 200 && beats.size() != 0; i++) cycle(tag);
      chk({tag, ".drained"}, beats.size(), 0);
   endtask

   initial begin
      rst_n        = 1;
      adc_valid    = 0;
      adc_data     = '0;
      adc_r1_mode  = 0;
      ch_enable    = 2'b11;
      enable       = 0;
      out_ready    = 1;
      overflow_clr = 0;
      #1 rst_n = 0;
      #1;
      chk("rst.valid", out_valid, 0);
      chk("rst.data", out_data, 0);
      chk("rst.level", fifo_level, 0);
      chk("rst.drops", drop_count, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n  = 1;
      enable = 1;

      // Two-channel set, both enabled
      adc_data  = {12'hFFF, 12'h001, 12'h800, 12'h7FF};
      adc_valid = 1;
      cycle("dir2");
      adc_valid = 0;
      chk("dir2.b1.data", out_data, 32'hF800_07FF);
      chk("dir2.b1.chan", out_chan, 0);
      chk("dir2.b1.sof", out_sof, 1);
      cycle("dir2");
      chk("dir2.b2.data", out_data, 32'hFFFF_0001);
      chk("dir2.b2.chan", out_chan, 1);
      chk("dir2.b2.sof", out_sof, 0);
      cycle("dir2");

      // Single-channel mode
      adc_r1_mode = 1;
      adc_valid   = 1;
      cycle("r1");
      adc_valid   = 0;
      adc_r1_mode = 0;
      chk("r1.data", out_data, 32'hF800_07FF);
      chk("r1.chan", out_chan, 0);
      chk("r1.sof", out_sof, 1);
      cycle("r1");
      chk("r1.single", out_valid, 0);

      // Only channel 1 enabled
      ch_enable = 2'b10;
      adc_valid = 1;
      cycle("m10");
      adc_valid = 0;
      chk("m10.data", out_data, 32'hFFFF_0001);
      chk("m10.chan", out_chan, 1);
      chk("m10.sof", out_sof, 1);
      cycle("m10");

      // Empty mask is ignored
      ch_enable = 2'b00;
      adc_valid = 1;
      repeat (3) cycle("m00");
      adc_valid = 0;
      chk("m00.level", fifo_level, 0);
      chk("m00.overflow", overflow, 0);

      // Overflow: 17 sets with the output stalled
      ch_enable = 2'b11;
      out_ready = 0;
      for (int i = 0; i < 17; i++) begin
         adc_data  = 48'({$urandom(), $urandom()});
         adc_valid = 1;
         cycle("ovf.fill");
      end
      chk("ovf.level", fifo_level, 16);
      chk("ovf.flag", overflow, 1);
      chk("ovf.count", drop_count, 1);
      drain("ovf.drain");
      overflow_clr = 1;
      cycle("ovf.clr");
      overflow_clr = 0;
      chk("ovf.clr.flag", overflow, 0);
      chk("ovf.clr.count", drop_count, 0);

      // Full FIFO with a last-beat pop in the same cycle
      adc_r1_mode = 1;
      out_ready   = 0;
      for (int i = 0; i < 16; i++) begin
         adc_data  = 48'({$urandom(), $urandom()});
         adc_valid = 1;
         cycle("full.fill");
      end
      adc_data  = 48'({$urandom(), $urandom()});
      out_ready = 1;
      cycle("full.pop");
      chk("full.pop.count", drop_count, 0);
      chk("full.pop.level", fifo_level, 16);
      out_ready = 0;
      cycle("full.nopop");
      chk("full.nopop.count", drop_count, 1);
      drain("full.drain");
      adc_r1_mode  = 0;
      overflow_clr = 1;
      cycle("full.clr");
      overflow_clr = 0;

      // Enable falls after three sets
      out_ready = 0;
      for (int i = 0; i < 8; i++) begin
         if (i == 3) enable = 0;
         adc_data  = 48'({$urandom(), $urandom()});
         adc_valid = 1;
         cycle("en");
      end
      chk("en.level", fifo_level, 3);
      out_ready = 1;
      for (int i = 0; i < 8; i++) cycle("en.drain");
      chk("en.empty", fifo_level, 0);
      adc_valid = 0;
      enable    = 1;

      // Randomised traffic with random backpressure
      issued = 0;
      for (int cyc = 0; cyc < 20000 && issued < 1000; cyc++) begin
         adc_valid    = ($urandom_range(2) == 0);
         adc_data     = 48'({$urandom(), $urandom()});
         ch_enable    = 2'($urandom_range(3));
         adc_r1_mode  = ($urandom_range(7) == 0);
         out_ready    = $urandom_range(1);
         overflow_clr = ($urandom_range(63) == 0);
         cycle("rnd");
      end
      chk("rnd.issued", issued >= 1000, 1);
      overflow_clr = 0;
      adc_r1_mode  = 0;
      ch_enable    = 2'b11;
      drain("rnd.drain");

      // Reset in the middle of a stream
      out_ready = 0;
      adc_valid = 1;
      repeat (2) cycle("mid");
      adc_valid = 0;
      chk("mid.pre.valid", out_valid, 1);
      @(posedge clk);
      #2 rst_n = 0;
      #1;
      chk("mid.rst.valid", out_valid, 0);
      chk("mid.rst.data", out_data, 0);
      chk("mid.rst.chan", out_chan, 0);
      chk("mid.rst.sof", out_sof, 0);
      chk("mid.rst.overflow", overflow, 0);
      chk("mid.rst.drops", drop_count, 0);
      chk("mid.rst.level", fifo_level, 0);
      beats.delete();
      sets_q  = 0;
      m_ovf   = 0;
      m_drops = 0;
      @(negedge clk);
      rst_n     = 1;
      out_ready = 1;
      repeat (2) cycle("mid.post");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
